// File: rtl/rca_accumulator.sv
// Burst accumulator: sums a valid/ready stream of unsigned operands through a
// ripple-carry adder and returns the modulo-2^N total with a sticky carry flag.

module rca_generate #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < n; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[n];

endmodule

module rca_accumulator #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] remaining;
  logic             ovf;
  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             beat;

  rca_generate #(
    .n(N)
  ) u_adder (
    .a   (acc),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Handshake outputs are decoded from state alone, so in_ready never depends on in_valid.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat && (remaining == CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= len;
          end
        end
        ACC: begin
          if (beat) begin
            acc       <= add_sum;
            ovf       <= ovf | add_cout;
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: hand-computed bursts covering overflow,
// zero-length bursts, input gaps, output back-pressure and mid-burst reset.

module tb_rca_accumulator;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_ovf;
  logic             busy;

  int compared;
  int mismatched;

  rca_accumulator #(
    .N    (N),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] l,
                               input logic v, input logic [N-1:0] d,
                               input logic r);
    start     = s;
    len       = l;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic rdy,
                          input logic b, input logic [N-1:0] s, input logic o);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    checkOutput({tag, ".busy"},      32'(busy),      32'(b));
    checkOutput({tag, ".out_sum"},   32'(out_sum),   32'(s));
    checkOutput({tag, ".out_ovf"},   32'(out_ovf),   32'(o));
  endtask

  initial begin
    logic        gap_valid [7];
    logic [15:0] gap_data  [7];

    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    len        = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;

    #12;
    checkAll("reset", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Burst of three back-to-back operands: 10 + 20 + 30.
    applyStimulus(1'b1, 8'd3, 1'b0, 16'd0, 1'b0);
    checkAll("b1_start", 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd10, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd20, 1'b0);
    checkAll("b1_beat2", 1'b0, 1'b1, 1'b1, 16'd30, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd30, 1'b0);
    checkAll("b1_done", 1'b1, 1'b0, 1'b1, 16'd60, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
    checkAll("b1_idle", 1'b0, 1'b0, 1'b0, 16'd60, 1'b0);

    // Wrapping burst: FFFF + 0002 = 0x10001.
    applyStimulus(1'b1, 8'd2, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'hFFFF, 1'b0);
    checkAll("b2_beat1", 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h0002, 1'b0);
    checkAll("b2_done", 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1);

    // Next burst must see the sticky flag cleared by start.
    applyStimulus(1'b1, 8'd1, 1'b0, 16'd0, 1'b0);
    checkAll("b3_start", 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd5, 1'b0);
    checkAll("b3_done", 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1);

    // Zero-length burst goes straight to DONE; offered data is never taken.
    applyStimulus(1'b1, 8'd0, 1'b1, 16'h1234, 1'b0);
    checkAll("b0_done", 1'b1, 1'b0, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'h1234, 1'b1);
    checkAll("b0_idle", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    // Four operands with bubbles; gap cycles carry junk data that must be ignored.
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_data  = '{16'd100, 16'hDEAD, 16'hBEEF, 16'd200, 16'hDEAD, 16'd300, 16'd400};
    applyStimulus(1'b1, 8'd4, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'd0, gap_valid[i], gap_data[i], 1'b0);
    end
    checkAll("b4_before_last", 1'b0, 1'b1, 1'b1, 16'd600, 1'b0);
    applyStimulus(1'b0, 8'd0, gap_valid[6], gap_data[6], 1'b0);
    checkAll("b4_done", 1'b1, 1'b0, 1'b1, 16'd1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'd7, 1'b1, 16'h0F0F, 1'b0);
      checkAll("b4_hold", 1'b1, 1'b0, 1'b1, 16'd1000, 1'b0);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
    checkAll("b4_idle", 1'b0, 1'b0, 1'b0, 16'd1000, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b0);
    checkAll("b4_stay_idle", 1'b0, 1'b0, 1'b0, 16'd1000, 1'b0);

    // Reset two beats into a five-operand burst.
    applyStimulus(1'b1, 8'd5, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd2, 1'b0);
    checkAll("b5_mid", 1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checkAll("b5_async_reset", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd9, 1'b0);
    checkAll("b5_no_resume", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    applyStimulus(1'b1, 8'd2, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd7, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 16'd8, 1'b0);
    checkAll("b6_done", 1'b1, 1'b0, 1'b1, 16'd15, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
    checkAll("b6_idle", 1'b0, 1'b0, 1'b0, 16'd15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
